wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among three writeback sources: ALU result, memory load and link-register write (jal/jalr return address).
- Replaces the purely combinational destination and source selection with an arbitrated, registered writeback stage.
- Generates the destination-select code and the writeback-source select code consumed by the existing 5-bit and 32-bit selection muxes.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- LINK_REG, 31, destination forced for link writes
- STARVE_MAX, 4, consecutive denied cycles before a requester is promoted to top priority (range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_stall  input  1  freeze: no grants while high
- alu_valid  input  1  ALU write request
- alu_ready  output  1  ALU grant (combinational)
- alu_rd  input  ADDR_W  rd field
- alu_rt  input  ADDR_W  rt field
- alu_use_rd  input  1  1 selects rd, 0 selects rt
- alu_data  input  DATA_W  ALU result
- ld_valid  input  1  load write request
- ld_ready  output  1  load grant
- ld_rt  input  ADDR_W  load destination
- ld_data  input  DATA_W  load data
- lnk_valid  input  1  link write request
- lnk_ready  output  1  link grant
- lnk_data  input  DATA_W  return address (PC+4)
- wr_en  output  1  register-file write enable
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- reg_dst  output  2  0=rt, 1=rd, 2=link register
- wb_sel  output  2  0=ALU, 1=load, 2=link

Behaviour:
- Transfer rule: a transfer occurs when valid && ready in the same cycle.
- Requester obligations: hold valid, address and data stable until granted; valid must not drop before the grant.
- Grant limit: at most one ready asserted per cycle. No ready is asserted while wb_stall=1 or rst_n=0.
- Default priority: load > link > ALU.
- Starvation counters: one 4-bit counter per source.
  - Increments each cycle the source is valid, not granted and wb_stall=0.
  - Clears on that source's grant or when it is not valid.
  - Holds its value while wb_stall=1.
  - Saturates at STARVE_MAX.
- Promotion: a counter at STARVE_MAX promotes its source above all others. If several are promoted, the default priority applies among the promoted sources.
- FSM states:
  - PRIO: normal fixed priority. Moves to STARVE when any counter reaches STARVE_MAX.
  - STARVE: the promoted source is granted on the first non-stalled cycle. Returns to PRIO when no counter is at STARVE_MAX.
- Latency: one cycle. The transfer in cycle N drives wr_en, wr_addr, wr_data, reg_dst and wb_sel in cycle N+1.
- No transfer: wr_en=0 and wr_addr/wr_data/reg_dst/wb_sel hold their previous values.
- Address per source:
  - ALU: alu_use_rd ? alu_rd : alu_rt, with reg_dst = alu_use_rd.
  - Load: ld_rt, with reg_dst=0.
  - Link: LINK_REG, with reg_dst=2.
- Register $zero: a transfer whose address is 0 is accepted (ready asserted, requester released) but wr_en stays 0. wr_addr, wr_data, reg_dst and wb_sel still update.
- Reserved codes: reg_dst=3 and wb_sel=3 are never produced.
- Reset (asynchronous, any time including mid-request):
  - wr_en=0, wr_addr=0, wr_data=0, reg_dst=0, wb_sel=0.
  - FSM returns to PRIO; all starvation counters clear.
  - Nothing in flight survives; requesters keep valid asserted and are re-arbitrated after reset release.
- Stall mid-starvation: STARVE state and counters hold; the promoted source is granted first after the stall releases.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined: adds the following 16-bit saturating counters, cleared by reset.
  - Output stat_alu: accepted ALU transfers.
  - Output stat_ld: accepted load transfers.
  - Output stat_lnk: accepted link transfers.
  - Output stat_zero_drop: accepted transfers to address 0.
  - Output stat_promote: cycles in which a grant went to a promoted source.
- Undefined: these ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Single ALU request: alu_valid=1, rd=8, use_rd=1, data=0x1234 -> alu_ready same cycle; next cycle wr_en=1, wr_addr=8, wr_data=0x1234, reg_dst=1, wb_sel=0.
- Simultaneous requests: all three valid in one cycle -> ld granted first, then lnk (wr_addr=31, reg_dst=2, wb_sel=2), then ALU, on three consecutive cycles with one-cycle writeback latency.
- Starvation: ld_valid held high with a new load each cycle, alu_valid high, STARVE_MAX=4 -> ALU denied 4 cycles, granted on the 5th; ld_ready=0 in that cycle; FSM returns to PRIO.
- $zero: ld_rt=0, data=0xDEAD -> ld_ready=1; next cycle wr_en=0, wr_data=0xDEAD; stat_zero_drop=1 when WB_ARB_STATS_EN is defined.
- Stall: wb_stall=1 for 3 cycles with all sources valid -> no ready asserted, counters unchanged, wr_en=0; grants resume the cycle after wb_stall falls.
- Reset mid-operation: rst_n pulled low asynchronously during an ALU grant cycle -> all outputs 0 immediately, counters clear; after release the held request is granted again and written once.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Arbitrated, registered register-file writeback port for ALU, load and link.
// Define WB_ARB_STATS_EN to add the transfer statistics counters.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int LINK_REG   = 31,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [ADDR_W-1:0] alu_rt,
  input  logic              alu_use_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rt,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              lnk_valid,
  output logic              lnk_ready,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        reg_dst,
`ifdef WB_ARB_STATS_EN
  output logic [15:0]       stat_alu,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_lnk,
  output logic [15:0]       stat_zero_drop,
  output logic [15:0]       stat_promote,
`endif
  output logic [1:0]        wb_sel
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic {PRIO, STARVE} st_t;

  st_t st, st_n;
  logic [3:0] c_alu, c_ld, c_lnk;
  logic p_alu, p_ld, p_lnk, any_p;
  logic g_alu, g_ld, g_lnk, xfer, en;
  logic [ADDR_W-1:0] a_n;
  logic [DATA_W-1:0] d_n;
  logic [1:0] dst_n, sel_n;

  assign p_alu = alu_valid && (c_alu == SMAX);
  assign p_ld  = ld_valid  && (c_ld  == SMAX);
  assign p_lnk = lnk_valid && (c_lnk == SMAX);
  assign any_p = p_alu | p_ld | p_lnk;
  assign en    = rst_n && !wb_stall;

  always_comb begin
    st_n  = st;
    g_alu = 1'b0;
    g_ld  = 1'b0;
    g_lnk = 1'b0;
    unique case (st)
      PRIO:    if (any_p) st_n = STARVE;
      STARVE:  if (!any_p) st_n = PRIO;
      default: st_n = PRIO;
    endcase
    // Promoted sources win; default order applies within each group.
    if (en) begin
      if (any_p) begin
        if (p_ld)       g_ld  = 1'b1;
        else if (p_lnk) g_lnk = 1'b1;
        else            g_alu = 1'b1;
      end else begin
        if (ld_valid)       g_ld  = 1'b1;
        else if (lnk_valid) g_lnk = 1'b1;
        else if (alu_valid) g_alu = 1'b1;
      end
    end
  end

  assign alu_ready = g_alu;
  assign ld_ready  = g_ld;
  assign lnk_ready = g_lnk;
  assign xfer      = g_alu | g_ld | g_lnk;

  always_comb begin
    a_n   = alu_use_rd ? alu_rd : alu_rt;
    d_n   = alu_data;
    dst_n = {1'b0, alu_use_rd};
    sel_n = 2'd0;
    unique case (1'b1)
      g_ld: begin
        a_n   = ld_rt;
        d_n   = ld_data;
        dst_n = 2'd0;
        sel_n = 2'd1;
      end
      g_lnk: begin
        a_n   = ADDR_W'(LINK_REG);
        d_n   = lnk_data;
        dst_n = 2'd2;
        sel_n = 2'd2;
      end
      default: ;
    endcase
  end

  function automatic logic [3:0] cnt_nx(
    input logic v, input logic g, input logic s,
    input logic [3:0] c
  );
    if (!v || g)     return 4'd0;
    else if (s)      return c;
    else if (c < SMAX) return c + 4'd1;
    else             return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= PRIO;
      c_alu <= '0;
      c_ld  <= '0;
      c_lnk <= '0;
    end else begin
      st    <= st_n;
      c_alu <= cnt_nx(alu_valid, g_alu, wb_stall, c_alu);
      c_ld  <= cnt_nx(ld_valid, g_ld, wb_stall, c_ld);
      c_lnk <= cnt_nx(lnk_valid, g_lnk, wb_stall, c_lnk);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      reg_dst <= '0;
      wb_sel  <= '0;
    end else begin
      wr_en <= xfer && (a_n != '0);
      if (xfer) begin
        wr_addr <= a_n;
        wr_data <= d_n;
        reg_dst <= dst_n;
        wb_sel  <= sel_n;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  function automatic logic [15:0] sat(
    input logic [15:0] c, input logic inc
  );
    return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  logic prm;
  assign prm = (g_alu & p_alu) | (g_ld & p_ld) | (g_lnk & p_lnk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alu       <= '0;
      stat_ld        <= '0;
      stat_lnk       <= '0;
      stat_zero_drop <= '0;
      stat_promote   <= '0;
    end else begin
      stat_alu       <= sat(stat_alu, g_alu);
      stat_ld        <= sat(stat_ld, g_ld);
      stat_lnk       <= sat(stat_lnk, g_lnk);
      stat_zero_drop <= sat(stat_zero_drop, xfer && (a_n == '0));
      stat_promote   <= sat(stat_promote, prm);
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: grants checked per cycle,
// expected writes queued at the grant and compared one cycle later.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_stall = 1'b0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [4:0]  alu_rd = '0, alu_rt = '0;
  logic        alu_use_rd = 1'b0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0, ld_ready;
  logic [4:0]  ld_rt = '0;
  logic [31:0] ld_data = '0;
  logic        lnk_valid = 1'b0, lnk_ready;
  logic [31:0] lnk_data = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  reg_dst, wb_sel;
`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_alu, stat_ld, stat_lnk, stat_zero_drop, stat_promote;
`endif

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_rt(alu_rt),
    .alu_use_rd(alu_use_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rt(ld_rt), .ld_data(ld_data),
    .lnk_valid(lnk_valid), .lnk_ready(lnk_ready),
    .lnk_data(lnk_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_dst(reg_dst),
`ifdef WB_ARB_STATS_EN
    .stat_alu(stat_alu), .stat_ld(stat_ld), .stat_lnk(stat_lnk),
    .stat_zero_drop(stat_zero_drop), .stat_promote(stat_promote),
`endif
    .wb_sel(wb_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  dst;
    logic [1:0]  sel;
  } wexp_t;

  wexp_t q[$];
  wexp_t last;
  int vecs = 0;
  int errs = 0;
  logic ld_refill = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // g: 0=alu 1=ld 2=lnk 3=no grant expected this cycle
  task automatic cyc(input int g);
    wexp_t e;
    logic [2:0] rdy;
    #1;
    rdy = (g == 3) ? 3'b000 : 3'(1 << g);
    chk("ready", {61'd0, lnk_ready, ld_ready, alu_ready}, {61'd0, rdy});
    if (g != 3) begin
      if (g == 0) begin
        e.a   = alu_use_rd ? alu_rd : alu_rt;
        e.d   = alu_data;
        e.dst = {1'b0, alu_use_rd};
        e.sel = 2'd0;
      end else if (g == 1) begin
        e.a   = ld_rt;
        e.d   = ld_data;
        e.dst = 2'd0;
        e.sel = 2'd1;
      end else begin
        e.a   = 5'd31;
        e.d   = lnk_data;
        e.dst = 2'd2;
        e.sel = 2'd2;
      end
      e.en = (e.a != 5'd0);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      last = e;
    end else begin
      e = last;
      e.en = 1'b0;
    end
    chk("wr_en", {63'd0, wr_en}, {63'd0, e.en});
    chk("wr_addr", {59'd0, wr_addr}, {59'd0, e.a});
    chk("wr_data", {32'd0, wr_data}, {32'd0, e.d});
    chk("reg_dst", {62'd0, reg_dst}, {62'd0, e.dst});
    chk("wb_sel", {62'd0, wb_sel}, {62'd0, e.sel});
    if (g == 0) alu_valid = 1'b0;
    if (g == 2) lnk_valid = 1'b0;
    if (g == 1) begin
      if (ld_refill) begin
        ld_rt   = ld_rt + 5'd1;
        ld_data = ld_data + 32'd1;
      end else ld_valid = 1'b0;
    end
  endtask

  initial begin
    last = '0;
    #2;
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_addr", {59'd0, wr_addr}, 64'd0);
    chk("rst_data", {32'd0, wr_data}, 64'd0);
    chk("rst_dst_sel", {60'd0, reg_dst, wb_sel}, 64'd0);
    alu_valid = 1'b1;
    #1;
    chk("rst_no_ready", {61'd0, lnk_ready, ld_ready, alu_ready}, 64'd0);
    alu_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(3);

    // single ALU request via rd
    alu_valid = 1'b1; alu_rd = 5'd8; alu_rt = 5'd3;
    alu_use_rd = 1'b1; alu_data = 32'h1234;
    cyc(0);
    cyc(3);

    // all three at once
    alu_valid = 1'b1; alu_use_rd = 1'b0; alu_rt = 5'd9;
    alu_data = 32'hA1A1;
    ld_valid = 1'b1; ld_rt = 5'd4; ld_data = 32'hB2B2;
    lnk_valid = 1'b1; lnk_data = 32'h0000_1004;
    cyc(1);
    cyc(2);
    cyc(0);
    cyc(3);

    // starvation of ALU behind back-to-back loads
    ld_refill = 1'b1;
    ld_valid = 1'b1; ld_rt = 5'd10; ld_data = 32'h100;
    alu_valid = 1'b1; alu_use_rd = 1'b1; alu_rd = 5'd12;
    alu_data = 32'hC3C3;
    for (int i = 0; i < 4; i++) cyc(1);
    cyc(0);
    cyc(1);
    ld_refill = 1'b0;
    cyc(1);
    cyc(3);

    // stall mid-starvation: counters must hold
    ld_refill = 1'b1;
    ld_valid = 1'b1; ld_rt = 5'd20; ld_data = 32'h200;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD4D4;
    lnk_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc(3);
    wb_stall = 1'b0;
    cyc(1);
    cyc(0);
    ld_refill = 1'b0;
    cyc(1);
    cyc(3);

    // stall with every source requesting
    alu_valid = 1'b1; ld_valid = 1'b1; lnk_valid = 1'b1;
    ld_rt = 5'd6; lnk_data = 32'h2008;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc(3);
    wb_stall = 1'b0;
    cyc(1);
    cyc(2);
    cyc(0);
    cyc(3);

    // asynchronous reset during an ALU grant
    alu_valid = 1'b1; alu_use_rd = 1'b1; alu_rd = 5'd7;
    alu_data = 32'h5555;
    #2;
    chk("pre_rst_ready", {63'd0, alu_ready}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {22'd0, wr_en, wr_addr, wr_data, reg_dst, wb_sel},
        64'd0);
    chk("mid_rst_ready", {61'd0, lnk_ready, ld_ready, alu_ready}, 64'd0);
    q.delete();
    last = '0;
    @(posedge clk);
    #1;
    chk("held_rst_out", {63'd0, wr_en}, 64'd0);
    rst_n = 1'b1;
    cyc(0);
    cyc(3);

    // write to $zero is accepted but not committed
    ld_valid = 1'b1; ld_rt = 5'd0; ld_data = 32'hDEAD;
    cyc(1);
`ifdef WB_ARB_STATS_EN
    chk("stat_zero", {48'd0, stat_zero_drop}, 64'd1);
    chk("stat_alu", {48'd0, stat_alu}, 64'd1);
    chk("stat_ld", {48'd0, stat_ld}, 64'd1);
`endif
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
